morse_letter_decoder: RTL and testbench

Upstream stage of the per-letter VGA draw modules in the Morse coder. It samples the raw Morse key, times each press to classify it as dot or dash, and collects up to 4 symbols per letter. When the letter gap expires it looks up the letter A–Z, holds the draw-enable `signal` high, and releases it when the draw module reports completion.

---
 rtl/morse_letter_decoder_pkg.sv | 60 ++++++
 rtl/morse_letter_decoder_if.sv | 16 +
 rtl/morse_letter_decoder_key_sync.sv | 30 +++
 rtl/morse_letter_decoder.sv | 164 ++++++++++++++++
 tb/tb_morse_letter_decoder.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/morse_letter_decoder_pkg.sv
// Purpose : shared FSM state type, letter codes and the Morse lookup table.
// Latency : n/a (types, constants and a pure function).
// Backpr. : n/a.
package morse_pkg;

   typedef enum logic [2:0] {IDLE, PRESS, GAP, EMIT, DRAW} state_t;

   // Letter codes: 0 means none/invalid, 1..26 map to A..Z.
   localparam logic [4:0] L_NONE = 5'd0;
   localparam logic [4:0] L_A = 5'd1,  L_B = 5'd2,  L_C = 5'd3,  L_D = 5'd4,  L_E = 5'd5;
   localparam logic [4:0] L_F = 5'd6,  L_G = 5'd7,  L_H = 5'd8,  L_I = 5'd9,  L_J = 5'd10;
   localparam logic [4:0] L_K = 5'd11, L_L = 5'd12, L_M = 5'd13, L_N = 5'd14, L_O = 5'd15;
   localparam logic [4:0] L_P = 5'd16, L_Q = 5'd17, L_R = 5'd18, L_S = 5'd19, L_T = 5'd20;
   localparam logic [4:0] L_U = 5'd21, L_V = 5'd22, L_W = 5'd23, L_X = 5'd24, L_Y = 5'd25;
   localparam logic [4:0] L_Z = 5'd26;

   // Symbols are shifted in newest-at-bit-0, so the first symbol keyed sits
   // in the highest used bit. 1 = dash, 0 = dot.
   function automatic logic [4:0] morse_lookup(input logic [2:0] count, input logic [3:0] bits);
      logic [4:0] code;
      code = L_NONE;
      case (count)
         3'd1: code = bits[0] ? L_T : L_E;
         3'd2: case (bits[1:0])
                  2'b00: code = L_I;
                  2'b01: code = L_A;
                  2'b10: code = L_N;
                  default: code = L_M;
               endcase
         3'd3: case (bits[2:0])
                  3'b000: code = L_S;
                  3'b001: code = L_U;
                  3'b010: code = L_R;
                  3'b011: code = L_W;
                  3'b100: code = L_D;
                  3'b101: code = L_K;
                  3'b110: code = L_G;
                  default: code = L_O;
               endcase
         3'd4: case (bits)
                  4'b0000: code = L_H;
                  4'b0001: code = L_V;
                  4'b0010: code = L_F;
                  4'b0100: code = L_L;
                  4'b0110: code = L_P;
                  4'b0111: code = L_J;
                  4'b1000: code = L_B;
                  4'b1001: code = L_X;
                  4'b1010: code = L_C;
                  4'b1011: code = L_Y;
                  4'b1100: code = L_Z;
                  4'b1101: code = L_Q;
                  default: code = L_NONE;
               endcase
         default: code = L_NONE;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/morse_letter_decoder_if.sv
// Purpose : bundles the key/draw handshake signals of the letter decoder.
// Latency : n/a (wiring only).
// Backpr. : none; finished is the only return path from the draw module.
// master = decoder side, slave = key source / draw module side.
interface morse_letter_decoder_if;
   logic       key;
   logic       finished;
   logic       signal;
   logic [4:0] letter;
   logic [3:0] symbols;
   logic [2:0] sym_count;
   logic       error;

   modport master (input key, finished, output signal, letter, symbols, sym_count, error);
   modport slave  (output key, finished, input signal, letter, symbols, sym_count, error);
endinterface

// File: rtl/morse_letter_decoder_key_sync.sv
// Purpose : brings the raw key into clk, provides key_s and rise/fall pulses.
// Latency : key change to rise/fall pulse visible 2 cycles, acted on at the 3rd edge.
// Backpr. : none; sampled every cycle.
// Ports: clk, reset (async high), key (async in), key_s, rise, fall.
module morse_key_sync (
   input  logic clk,
   input  logic reset,
   input  logic key,
   output logic key_s,
   output logic rise,
   output logic fall
);
   logic meta_q, sync_q, prev_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= key;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign key_s = sync_q;
   assign rise  = sync_q & ~prev_q;
   assign fall  = ~sync_q & prev_q;
endmodule

// File: rtl/morse_letter_decoder.sv
// Purpose : times key presses into dots/dashes, decodes a letter after the gap, drives draw enable.
// Latency : key edge acted on 3 cycles later; signal rises 1 cycle after the letter gap expires.
// Backpr. : signal held until a rising edge of finished or the draw timeout; key ignored meanwhile.
// Ports: clk, reset (async high), bus (master: key, finished in; signal, letter, symbols, sym_count, error out).
module morse_letter_decoder
   import morse_pkg::*;
#(
   parameter int MIN_PRESS    = 500_000,
   parameter int DOT_MAX      = 12_500_000,
   parameter int LETTER_GAP   = 37_500_000,
   parameter int DRAW_TIMEOUT = 512,
   parameter int CNT_W        = 26
) (
   input  logic clk,
   input  logic reset,
   morse_letter_decoder_if.master bus
);
   localparam int DRAW_W = (DRAW_TIMEOUT > 2) ? $clog2(DRAW_TIMEOUT) : 1;

   state_t              state_q, state_n;
   logic [CNT_W-1:0]    press_cnt_q, press_cnt_n;
   logic [CNT_W-1:0]    gap_cnt_q, gap_cnt_n;
   logic [DRAW_W-1:0]   draw_cnt_q, draw_cnt_n;
   logic [3:0]          symbols_q, symbols_n;
   logic [2:0]          sym_count_q, sym_count_n;
   logic                ovf_q, ovf_n;
   logic [4:0]          letter_q, letter_n;
   logic                signal_q, signal_n;
   logic                error_q, error_n;
   logic                fin_d_q;

   logic                key_s, key_rise, key_fall;
   logic                fin_rise, dash;
   logic [4:0]          lookup_code;

   morse_key_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .key   (bus.key),
      .key_s (key_s),
      .rise  (key_rise),
      .fall  (key_fall)
   );

   // fin_d tracks finished in every state, so a level already high on entry
   // to DRAW never looks like an edge.
   assign fin_rise    = bus.finished & ~fin_d_q;
   assign dash        = press_cnt_q > CNT_W'(DOT_MAX);
   assign lookup_code = morse_lookup(sym_count_q, symbols_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         press_cnt_q <= '0;
         gap_cnt_q   <= '0;
         draw_cnt_q  <= '0;
         symbols_q   <= '0;
         sym_count_q <= '0;
         ovf_q       <= 1'b0;
         letter_q    <= '0;
         signal_q    <= 1'b0;
         error_q     <= 1'b0;
         fin_d_q     <= 1'b0;
      end else begin
         state_q     <= state_n;
         press_cnt_q <= press_cnt_n;
         gap_cnt_q   <= gap_cnt_n;
         draw_cnt_q  <= draw_cnt_n;
         symbols_q   <= symbols_n;
         sym_count_q <= sym_count_n;
         ovf_q       <= ovf_n;
         letter_q    <= letter_n;
         signal_q    <= signal_n;
         error_q     <= error_n;
         fin_d_q     <= bus.finished;
      end
   end

   always_comb begin
      state_n     = state_q;
      press_cnt_n = press_cnt_q;
      gap_cnt_n   = gap_cnt_q;
      draw_cnt_n  = draw_cnt_q;
      symbols_n   = symbols_q;
      sym_count_n = sym_count_q;
      ovf_n       = ovf_q;
      letter_n    = letter_q;
      signal_n    = signal_q;
      error_n     = error_q;

      case (state_q)
         IDLE: begin
            press_cnt_n = '0;
            gap_cnt_n   = '0;
            draw_cnt_n  = '0;
            if (key_rise) begin
               error_n = 1'b0;
               state_n = PRESS;
            end
         end
         PRESS: begin
            if (press_cnt_q != '1)
               press_cnt_n = press_cnt_q + CNT_W'(1);
            if (key_fall) begin
               gap_cnt_n = '0;
               if (press_cnt_q < CNT_W'(MIN_PRESS)) begin
                  // Glitch: drop it, but keep waiting out the gap if a letter is in progress.
                  state_n = (sym_count_q != 3'd0) ? GAP : IDLE;
               end else begin
                  if (sym_count_q < 3'd4) begin
                     symbols_n   = {symbols_q[2:0], dash};
                     sym_count_n = sym_count_q + 3'd1;
                  end else begin
                     ovf_n = 1'b1;
                  end
                  state_n = GAP;
               end
            end
         end
         GAP: begin
            gap_cnt_n = gap_cnt_q + CNT_W'(1);
            // A new press on the expiry cycle still belongs to this letter.
            if (key_rise) begin
               press_cnt_n = '0;
               state_n     = PRESS;
            end else if (gap_cnt_q == CNT_W'(LETTER_GAP - 1)) begin
               state_n = EMIT;
            end
         end
         EMIT: begin
            if (ovf_q || (lookup_code == L_NONE)) begin
               letter_n    = L_NONE;
               error_n     = 1'b1;
               symbols_n   = '0;
               sym_count_n = '0;
               ovf_n       = 1'b0;
               state_n     = IDLE;
            end else begin
               letter_n   = lookup_code;
               signal_n   = 1'b1;
               draw_cnt_n = '0;
               state_n    = DRAW;
            end
         end
         DRAW: begin
            draw_cnt_n = draw_cnt_q + DRAW_W'(1);
            if (fin_rise || (draw_cnt_q == DRAW_W'(DRAW_TIMEOUT - 1))) begin
               signal_n    = 1'b0;
               symbols_n   = '0;
               sym_count_n = '0;
               ovf_n       = 1'b0;
               state_n     = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.signal    = signal_q;
   assign bus.letter    = letter_q;
   assign bus.symbols   = symbols_q;
   assign bus.sym_count = sym_count_q;
   assign bus.error     = error_q;
endmodule

// File: tb/tb_morse_letter_decoder.sv
// Purpose : directed bench for the Morse letter decoder with small timing parameters.
// Latency : release-to-signal is 3 sync cycles + 10 gap cycles + 1 emit cycle = 14.
// Backpr. : finished pulses or the 16-cycle timeout end each draw.
module tb_morse_letter_decoder;
   logic clk;
   logic reset;
   int   total;
   int   bad;

   morse_letter_decoder_if bus_i ();

   morse_letter_decoder #(
      .MIN_PRESS    (2),
      .DOT_MAX      (4),
      .LETTER_GAP   (10),
      .DRAW_TIMEOUT (16),
      .CNT_W        (26)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int n);
      bus_i.key = 1'b1;
      tick(n);
      bus_i.key = 1'b0;
   endtask

   task automatic fin_pulse();
      bus_i.finished = 1'b1;
      tick(1);
      bus_i.finished = 1'b0;
   endtask

   initial begin
      int seen;
      int hi;
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus_i.key = 1'b0;
      bus_i.finished = 1'b0;
      tick(3);
      chk("rst_signal", bus_i.signal, 0);
      chk("rst_letter", bus_i.letter, 0);
      chk("rst_symbols", bus_i.symbols, 0);
      chk("rst_count", bus_i.sym_count, 0);
      chk("rst_error", bus_i.error, 0);
      reset = 1'b0;
      tick(2);

      // 1: four dots -> H
      for (int i = 0; i < 4; i++) begin
         press(3);
         if (i < 3) tick(3);
      end
      tick(13);
      chk("t1_sig_early", bus_i.signal, 0);
      chk("t1_count", bus_i.sym_count, 4);
      chk("t1_symbols", bus_i.symbols, 0);
      tick(1);
      chk("t1_sig", bus_i.signal, 1);
      chk("t1_letter", bus_i.letter, 8);
      chk("t1_error", bus_i.error, 0);
      fin_pulse();
      chk("t1_sig_drop", bus_i.signal, 0);
      chk("t1_count_clr", bus_i.sym_count, 0);
      chk("t1_letter_hold", bus_i.letter, 8);
      tick(5);

      // 2: dot, dash -> A; finished 20 cycles after release
      press(3);
      tick(3);
      press(8);
      tick(14);
      chk("t2_sig", bus_i.signal, 1);
      chk("t2_letter", bus_i.letter, 1);
      chk("t2_symbols", bus_i.symbols, 4'b0001);
      chk("t2_count", bus_i.sym_count, 2);
      tick(6);
      chk("t2_sig_hold", bus_i.signal, 1);
      fin_pulse();
      chk("t2_sig_drop", bus_i.signal, 0);
      chk("t2_count_clr", bus_i.sym_count, 0);
      tick(5);

      // 3: five dots -> overflow, error, no draw
      for (int i = 0; i < 5; i++) begin
         press(3);
         if (i < 4) tick(3);
      end
      tick(14);
      chk("t3_letter", bus_i.letter, 0);
      chk("t3_error", bus_i.error, 1);
      chk("t3_count_clr", bus_i.sym_count, 0);
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         tick(1);
         if (bus_i.signal) seen = 1;
      end
      chk("t3_no_signal", seen, 0);
      bus_i.key = 1'b1;
      tick(2);
      chk("t3_err_before_edge", bus_i.error, 1);
      tick(1);
      chk("t3_err_cleared", bus_i.error, 0);
      bus_i.key = 1'b0;
      tick(40);

      // 4: single-cycle glitch with no symbols
      press(1);
      seen = 0;
      for (int c = 0; c < 30; c++) begin
         tick(1);
         if (bus_i.signal || bus_i.sym_count != 3'd0) seen = 1;
      end
      chk("t4_quiet", seen, 0);
      chk("t4_error", bus_i.error, 0);
      chk("t4_letter_hold", bus_i.letter, 5);

      // 5: finished stuck high -> timeout of 16 cycles, key ignored in DRAW
      bus_i.finished = 1'b1;
      tick(2);
      press(3);
      tick(14);
      chk("t5_sig", bus_i.signal, 1);
      chk("t5_letter", bus_i.letter, 5);
      hi = 1;
      for (int c = 0; c < 40; c++) begin
         if (c == 1) bus_i.key = 1'b1;
         if (c == 4) bus_i.key = 1'b0;
         tick(1);
         if (bus_i.signal) hi++;
      end
      chk("t5_high_cycles", hi, 16);
      chk("t5_count", bus_i.sym_count, 0);
      chk("t5_sig_low", bus_i.signal, 0);
      bus_i.finished = 1'b0;
      tick(3);

      // 6: reset in the middle of the second press
      press(3);
      tick(3);
      bus_i.key = 1'b1;
      tick(4);
      chk("t6_pre_count", bus_i.sym_count, 1);
      reset = 1'b1;
      #1;
      chk("t6_signal", bus_i.signal, 0);
      chk("t6_letter", bus_i.letter, 0);
      chk("t6_symbols", bus_i.symbols, 0);
      chk("t6_count", bus_i.sym_count, 0);
      chk("t6_error", bus_i.error, 0);
      bus_i.key = 1'b0;
      tick(2);
      reset = 1'b0;
      tick(2);
      press(3);
      tick(14);
      chk("t6_sig", bus_i.signal, 1);
      chk("t6_letter_e", bus_i.letter, 5);
      chk("t6_count_e", bus_i.sym_count, 1);
      chk("t6_symbols_e", bus_i.symbols, 0);
      fin_pulse();
      chk("t6_sig_drop", bus_i.signal, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
